// File: rtl/onehot_sequencer.sv
// onehot_sequencer: registered binary-to-one-hot select with wrap-around
// stepping. It holds an index/valid pair. onehot is decoded from the next
// index and registered, so no input has a combinational path to any output.
module onehot_sequencer #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] binary,
  output logic [DEPTH-1:0] onehot,
  output logic [WIDTH-1:0] index,
  output logic             valid_out,
  output logic             range_err,
  output logic             wrap
);

  typedef enum logic [1:0] {
    MODE_HOLD      = 2'b00,
    MODE_LOAD      = 2'b01,
    MODE_STEP_UP   = 2'b10,
    MODE_STEP_DOWN = 2'b11
  } mode_e;

  localparam logic [WIDTH-1:0] LAST_IDX = WIDTH'(DEPTH - 1);
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

  logic [WIDTH-1:0] index_q,     index_d;
  logic             valid_q,     valid_d;
  logic [DEPTH-1:0] onehot_q,    onehot_d;
  logic             range_err_q, range_err_d;
  logic             wrap_q,      wrap_d;

  // Next-state: apply the qualified command to the held select.
  always_comb begin
    // NOTE: every always_comb output gets a default first. A path that
    // leaves a variable unassigned would otherwise infer a latch.
    index_d     = index_q;
    valid_d     = valid_q;
    range_err_d = 1'b0;
    wrap_d      = 1'b0;

    if (en) begin
      unique case (mode_e'(mode))
        MODE_LOAD: begin
          if (int'(binary) < DEPTH) begin
            index_d = binary;
            valid_d = 1'b1;
          end else begin
            index_d     = '0;
            valid_d     = 1'b0;
            range_err_d = 1'b1;
          end
        end
        MODE_STEP_UP: begin
          if (valid_q) begin
            if (index_q == LAST_IDX) begin
              index_d = '0;
              wrap_d  = 1'b1;
            end else begin
              index_d = index_q + ONE;
            end
          end
        end
        MODE_STEP_DOWN: begin
          if (valid_q) begin
            if (index_q == '0) begin
              index_d = LAST_IDX;
              wrap_d  = 1'b1;
            end else begin
              index_d = index_q - ONE;
            end
          end
        end
        default: ; // MODE_HOLD: keep select, pulses already cleared
      endcase
    end
  end

  // Decode the next index so the registered onehot matches index exactly.
  // Bits at DEPTH and above do not exist, so the rotation is modulo DEPTH.
  always_comb begin
    onehot_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      onehot_d[i] = valid_d && (int'(index_d) == i);
    end
  end

  // State and pulse registers. Reset clears the select immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      index_q     <= '0;
      valid_q     <= 1'b0;
      onehot_q    <= '0;
      range_err_q <= 1'b0;
      wrap_q      <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments. Every flop
      // then samples its pre-edge value, whatever the statement order.
      index_q     <= index_d;
      valid_q     <= valid_d;
      onehot_q    <= onehot_d;
      range_err_q <= range_err_d;
      wrap_q      <= wrap_d;
    end
  end

  assign onehot    = onehot_q;
  assign index     = index_q;
  assign valid_out = valid_q;
  assign range_err = range_err_q;
  assign wrap      = wrap_q;

endmodule

// File: tb/tb_onehot_sequencer.sv
// Directed bench for onehot_sequencer. It runs two instances driven by the
// same stimulus: DEPTH=16 (full range) and DEPTH=10 (out-of-range selects).
// Each test task computes its expected values by hand. A negedge scoreboard
// checks the popcount/index invariant on both instances.
module tb_onehot_sequencer;

  localparam logic [1:0] HOLD = 2'b00;
  localparam logic [1:0] LOAD = 2'b01;
  localparam logic [1:0] UP   = 2'b10;
  localparam logic [1:0] DOWN = 2'b11;

  logic        clk    = 1'b0;
  logic        rst_n  = 1'b0;
  logic        en     = 1'b0;
  logic [1:0]  mode   = HOLD;
  logic [3:0]  binary = '0;

  logic [15:0] oh16;
  logic [3:0]  ix16;
  logic        v16, re16, wr16;
  logic [9:0]  oh10;
  logic [3:0]  ix10;
  logic        v10, re10, wr10;

  int n_checks = 0;
  int n_fail   = 0;

  onehot_sequencer #(.WIDTH(4), .DEPTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .binary(binary),
    .onehot(oh16), .index(ix16), .valid_out(v16), .range_err(re16), .wrap(wr16)
  );

  onehot_sequencer #(.WIDTH(4), .DEPTH(10)) dut10 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .binary(binary),
    .onehot(oh10), .index(ix10), .valid_out(v10), .range_err(re10), .wrap(wr10)
  );

  always #5 clk = ~clk;

  // Invariant scoreboard: popcount(onehot) == valid_out, onehot == 1<<index.
  always @(negedge clk) begin
    n_checks++;
    if (($countones(oh16) != int'(v16)) || ($countones(oh10) != int'(v10)) ||
        (v16 && (oh16 !== (16'h1 << ix16))) || (v10 && (oh10 !== (10'h1 << ix10))) ||
        (!v16 && (ix16 !== 4'h0)) || (!v10 && (ix10 !== 4'h0))) begin
      n_fail++;
      $display("FAIL invariant t=%0t got oh16=%h ix16=%0d v16=%b oh10=%h ix10=%0d v10=%b want consistent one-hot/index/valid",
               $time, oh16, ix16, v16, oh10, ix10, v10);
    end
  end

  // Drive one command, then sample #1 after the edge that accepts it.
  task automatic cmd(input logic e, input logic [1:0] m, input logic [3:0] b);
    en = e; mode = m; binary = b;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #12;
    n_checks++;
    if ({oh16, ix16, v16, re16, wr16, oh10, ix10, v10, re10, wr10} !== 40'h0) begin
      n_fail++;
      $display("FAIL reset got oh16=%h ix16=%0d v/re/wr=%b%b%b oh10=%h want all zero",
               oh16, ix16, v16, re16, wr16, oh10);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_load_hold;
    cmd(1'b1, LOAD, 4'd5);
    n_checks++;
    if ({oh16, ix16, v16, re16, wr16} !== {16'h0020, 4'd5, 3'b100}) begin
      n_fail++;
      $display("FAIL load5 got %h/%0d/%b%b%b want 0020/5/100", oh16, ix16, v16, re16, wr16);
    end
    for (int i = 0; i < 3; i++) begin
      cmd(1'b0, LOAD, 4'd3);
      n_checks++;
      if ({oh16, ix16, v16, re16, wr16} !== {16'h0020, 4'd5, 3'b100}) begin
        n_fail++;
        $display("FAIL en0_hold[%0d] got %h/%0d/%b%b%b want 0020/5/100", i, oh16, ix16, v16, re16, wr16);
      end
    end
    cmd(1'b1, HOLD, 4'd9);
    n_checks++;
    if ({oh16, ix16, v16, re16, wr16} !== {16'h0020, 4'd5, 3'b100}) begin
      n_fail++;
      $display("FAIL mode_hold got %h/%0d/%b%b%b want 0020/5/100", oh16, ix16, v16, re16, wr16);
    end
  endtask

  task automatic test_step_up_wrap;
    logic [15:0] exp_oh [4] = '{16'h4000, 16'h8000, 16'h0001, 16'h0002};
    logic [3:0]  exp_ix [4] = '{4'd14, 4'd15, 4'd0, 4'd1};
    logic        exp_wr [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      if (i == 0) cmd(1'b1, LOAD, 4'd14);
      else        cmd(1'b1, UP, 4'd0);
      n_checks++;
      if ({oh16, ix16, v16, re16, wr16} !== {exp_oh[i], exp_ix[i], 1'b1, 1'b0, exp_wr[i]}) begin
        n_fail++;
        $display("FAIL step_up[%0d] got %h/%0d/wrap=%b want %h/%0d/wrap=%b",
                 i, oh16, ix16, wr16, exp_oh[i], exp_ix[i], exp_wr[i]);
      end
    end
  endtask

  task automatic test_step_down_wrap;
    logic [15:0] exp_oh [3] = '{16'h0001, 16'h8000, 16'h4000};
    logic [3:0]  exp_ix [3] = '{4'd0, 4'd15, 4'd14};
    logic        exp_wr [3] = '{1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      if (i == 0) cmd(1'b1, LOAD, 4'd0);
      else        cmd(1'b1, DOWN, 4'd0);
      n_checks++;
      if ({oh16, ix16, v16, re16, wr16} !== {exp_oh[i], exp_ix[i], 1'b1, 1'b0, exp_wr[i]}) begin
        n_fail++;
        $display("FAIL step_down[%0d] got %h/%0d/wrap=%b want %h/%0d/wrap=%b",
                 i, oh16, ix16, wr16, exp_oh[i], exp_ix[i], exp_wr[i]);
      end
    end
  endtask

  task automatic test_depth10_range;
    logic [1:0]  cm     [6] = '{LOAD, UP, DOWN, LOAD, UP, DOWN};
    logic [3:0]  bv     [6] = '{4'd9, 4'd0, 4'd0, 4'd12, 4'd0, 4'd0};
    logic [16:0] exp10  [6] = '{{10'h200, 4'd9, 3'b100}, {10'h001, 4'd0, 3'b101},
                                {10'h200, 4'd9, 3'b101}, {10'h000, 4'd0, 3'b010},
                                {10'h000, 4'd0, 3'b000}, {10'h000, 4'd0, 3'b000}};
    for (int i = 0; i < 6; i++) begin
      cmd(1'b1, cm[i], bv[i]);
      n_checks++;
      if ({oh10, ix10, v10, re10, wr10} !== exp10[i]) begin
        n_fail++;
        $display("FAIL depth10[%0d] got %h/%0d/%b%b%b want %h", i, oh10, ix10, v10, re10, wr10, exp10[i]);
      end
      // Select 12 is legal for the 16-deep instance: no range error there.
      if (i == 3) begin
        n_checks++;
        if ({oh16, ix16, v16, re16, wr16} !== {16'h1000, 4'd12, 3'b100}) begin
          n_fail++;
          $display("FAIL depth16_load12 got %h/%0d/%b%b%b want 1000/12/100", oh16, ix16, v16, re16, wr16);
        end
      end
    end
  endtask

  task automatic test_reset_mid;
    cmd(1'b1, LOAD, 4'd7);
    cmd(1'b1, UP, 4'd0);
    cmd(1'b1, UP, 4'd0);
    n_checks++;
    if ({oh16, ix16, v16} !== {16'h0200, 4'd9, 1'b1}) begin
      n_fail++;
      $display("FAIL pre_reset got %h/%0d/%b want 0200/9/1", oh16, ix16, v16);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({oh16, ix16, v16, re16, wr16, oh10, ix10, v10, re10, wr10} !== 40'h0) begin
      n_fail++;
      $display("FAIL async_reset got %h/%0d/%b%b%b oh10=%h want all zero", oh16, ix16, v16, re16, wr16, oh10);
    end
    @(negedge clk);
    rst_n = 1'b1;
    cmd(1'b1, UP, 4'd0);
    n_checks++;
    if ({oh16, ix16, v16, re16, wr16} !== 23'h0) begin
      n_fail++;
      $display("FAIL step_after_reset got %h/%0d/%b%b%b want all zero", oh16, ix16, v16, re16, wr16);
    end
  endtask

  task automatic test_sweep;
    logic [15:0] e16;
    logic [16:0] e10;
    for (int b = 0; b < 17; b++) begin
      logic [3:0] bb;
      bb = (b == 16) ? 4'd15 : 4'(b);  // last entry reloads 15: no pulse
      cmd(1'b1, LOAD, bb);
      e16 = 16'h1 << bb;
      e10 = (bb < 4'd10) ? {10'h1 << bb, bb, 3'b100} : {10'h0, 4'd0, 3'b010};
      n_checks++;
      if ({oh16, ix16, v16, re16, wr16} !== {e16, bb, 3'b100}) begin
        n_fail++;
        $display("FAIL sweep16[%0d] got %h/%0d/%b%b%b want %h/%0d/100", bb, oh16, ix16, v16, re16, wr16, e16, bb);
      end
      n_checks++;
      if ({oh10, ix10, v10, re10, wr10} !== e10) begin
        n_fail++;
        $display("FAIL sweep10[%0d] got %h/%0d/%b%b%b want %h", bb, oh10, ix10, v10, re10, wr10, e10);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_hold();
    test_step_up_wrap();
    test_step_down_wrap();
    test_depth10_range();
    test_reset_mid();
    test_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/onehot_sequencer.md
Name: onehot_sequencer

Overview:
Registered, parametrised successor to the 4x16 combinational decoder. Turns a WIDTH-bit binary select into a DEPTH-wide one-hot vector and holds it in a register. The held select can then be stepped up or down, with wrap-around, without re-presenting a binary value. The block drives ALU operation-select and register-file write-enable lines that must stay stable across cycles, and it flags out-of-range selects when DEPTH < 2**WIDTH.

Parameters:
WIDTH, 4, bit width of binary select input and index output (1..8)
DEPTH, 16, number of one-hot outputs; 2 <= DEPTH <= 2**WIDTH

Ports:
clk  input  1  system clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
en  input  1  command qualifier; when 0 the command is ignored and state holds
mode  input  2  command: 00 HOLD, 01 LOAD, 10 STEP_UP, 11 STEP_DOWN
binary  input  WIDTH  select value; sampled only on LOAD
onehot  output  DEPTH  registered one-hot select; all-zero when not valid
index  output  WIDTH  binary index of the set onehot bit; 0 when not valid
valid_out  output  1  1 when onehot holds exactly one set bit
range_err  output  1  one-cycle pulse: LOAD with binary >= DEPTH
wrap  output  1  one-cycle pulse: a STEP crossed DEPTH-1 <-> 0

Behaviour:
- Reset: asynchronous assert when rst_n=0; synchronous-release semantics are not provided by this block.
  - During reset: onehot=0, index=0, valid_out=0, range_err=0, wrap=0.
  - A reset in the middle of stepping discards the current select immediately.
- Latency: one cycle. A command accepted at edge k is visible on all outputs after edge k.
- range_err and wrap are registered pulses. Both default to 0 every cycle unless the rule below sets them.
- en=0, or mode=HOLD: onehot, index and valid_out hold; range_err=0, wrap=0.
- LOAD, binary < DEPTH:
  - onehot = 1 << binary, index = binary, valid_out=1.
  - Reloading the currently held value is legal; no pulse is generated.
- LOAD, binary >= DEPTH (only possible when DEPTH < 2**WIDTH):
  - onehot=0, index=0, valid_out=0, range_err=1 for one cycle.
  - Any previous select is cleared.
- STEP_UP, valid_out=1:
  - index < DEPTH-1: index+1, onehot rotates left by one.
  - index = DEPTH-1: index=0, onehot=1, wrap=1.
- STEP_DOWN, valid_out=1:
  - index > 0: index-1, onehot rotates right by one.
  - index = 0: index=DEPTH-1, onehot bit DEPTH-1 set, wrap=1.
- STEP_UP or STEP_DOWN with valid_out=0: no state change, no pulses. Stepping never creates a select from the empty state.
- Rotation is modulo DEPTH, not modulo 2**WIDTH. Bits DEPTH..2**WIDTH-1 never exist.
- Invariant: onehot has popcount 1 when valid_out=1 and popcount 0 otherwise. index always equals the encoded position of onehot.
- Implementation: internal state may be index-only, with onehot decoded from a register. However, onehot must be a registered output with no combinational path from any input.
- No state is held beyond onehot, index, valid_out and the two pulse flops.

Test Plan:
1. Reset, then LOAD binary=5 (WIDTH=4, DEPTH=16) -> next cycle onehot=16'h0020, index=5, valid_out=1, range_err=0. Hold en=0 for 3 cycles -> outputs unchanged.
2. LOAD 14, then STEP_UP x3 -> successive onehot 16'h4000, 16'h8000, 16'h0001 (wrap=1 on that cycle only), 16'h0002; index 14, 15, 0, 1.
3. LOAD 0, then STEP_DOWN -> onehot=16'h8000, index=15, wrap=1 one cycle. A further STEP_DOWN -> onehot 16'h4000, wrap=0.
4. DEPTH=10, WIDTH=4: LOAD 9 -> onehot=10'h200. Then LOAD 12 -> onehot=0, valid_out=0, range_err=1 for one cycle. STEP_UP afterwards -> outputs stay 0, no pulses.
5. LOAD 7 and STEP_UP twice, then assert rst_n=0 mid-cycle -> outputs go 0 immediately, before the next clock edge. After release, STEP_UP -> still 0 and valid_out=0.
6. Exhaustive sweep: LOAD every binary 0..15 (DEPTH=16) -> onehot equals 1<<binary and index equals binary every cycle. Scoreboard checks popcount(onehot) == valid_out throughout.
